// File: rtl/mix_normalizer.sv
// mix_normalizer: averages the mixer sum over the active-channel count with a bit-serial restoring divider.
module mix_normalizer #(
  parameter int SUM_W = 12,
  parameter int CNT_W = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [SUM_W-1:0] mix_sum,
  input  logic [CNT_W-1:0] num_signals,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] sample_norm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = $clog2(SUM_W);
  localparam logic [CW-1:0] LAST = CW'(SUM_W - 1);
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  state_t state;
  logic [SUM_W-1:0] dividend, quotient, quo_nx;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W:0] remainder, rem_sh, rem_nx;
  logic [CW-1:0] count;
  logic ge, sat;
  assign rem_sh = {remainder[CNT_W-1:0], dividend[SUM_W-1]};
  assign ge = rem_sh >= {1'b0, divisor};
  assign rem_nx = ge ? rem_sh - {1'b0, divisor} : rem_sh;
  assign quo_nx = {quotient[SUM_W-2:0], ge};
  assign sat = |quo_nx[SUM_W-1:OUT_W];
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      busy <= 1'b0;
      out_valid <= 1'b0;
      sample_norm <= '0;
      dividend <= '0;
      divisor <= '0;
      remainder <= '0;
      quotient <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dividend <= mix_sum;
          divisor <= num_signals;
          remainder <= '0;
          quotient <= '0;
          count <= '0;
          in_ready <= 1'b0;
          if (num_signals == '0) begin
            state <= DONE;
            out_valid <= 1'b1;
            sample_norm <= '0;
          end else begin
            state <= DIVIDE;
            busy <= 1'b1;
          end
        end
        DIVIDE: begin
          remainder <= rem_nx;
          quotient <= quo_nx;
          dividend <= {dividend[SUM_W-2:0], 1'b0};
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            busy <= 1'b0;
            out_valid <= 1'b1;
            sample_norm <= sat ? '1 : quo_nx[OUT_W-1:0];
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_normalizer.sv
// tb_mix_normalizer: timeline model of the handshake plus plain-division results, with directed and random traffic.
module tb_mix_normalizer;
  logic clk = 0, nrst = 0, in_valid = 0, out_ready = 0;
  logic [11:0] mix_sum = 0;
  logic [3:0] num_signals = 0;
  logic in_ready, out_valid, busy;
  logic [7:0] sample_norm;
  int tests = 0, fails = 0;
  bit chk_on = 0;

  mix_normalizer dut (
    .clk(clk), .nrst(nrst), .mix_sum(mix_sum), .num_signals(num_signals),
    .in_valid(in_valid), .in_ready(in_ready), .sample_norm(sample_norm),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: an accepted pair yields min(floor(s/n),255) after 12 busy cycles, or 0 at once when n==0.
  bit m_ir = 1, m_busy = 0, m_ov = 0;
  int m_s = 0, m_pend = 0, m_left = 0;
  always @(posedge clk) begin
    if (!nrst) begin
      m_ir = 1; m_busy = 0; m_ov = 0; m_s = 0; m_left = 0;
    end else if (m_ir && in_valid) begin
      m_ir = 0;
      m_pend = (num_signals == 0) ? 0 : int'(mix_sum) / int'(num_signals);
      if (m_pend > 255) m_pend = 255;
      if (num_signals == 0) begin m_ov = 1; m_s = 0; end
      else begin m_busy = 1; m_left = 12; end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_ov = 1; m_s = m_pend; end
    end else if (m_ov && out_ready) begin
      m_ov = 0; m_ir = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("in_ready", int'(in_ready), int'(m_ir));
    chk("busy", int'(busy), int'(m_busy));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("sample_norm", int'(sample_norm), m_s);
  end

  task automatic run(input int s, input int n, input int exp, input int hold);
    int edges, bcnt;
    @(negedge clk);
    mix_sum = 12'(s); num_signals = 4'(n); in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    edges = 1; bcnt = 0;
    while (!out_valid && edges < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      edges++;
    end
    chk("latency_edges", edges, (n == 0) ? 1 : 13);
    chk("busy_cycles", bcnt, (n == 0) ? 0 : 12);
    chk("result", int'(sample_norm), exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; mix_sum = 12'($urandom); num_signals = 4'($urandom);
      @(negedge clk);
      chk("hold_sample", int'(sample_norm), exp);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_valid", int'(out_valid), 0);
    chk("post_ready", int'(in_ready), 1);
    chk("post_keep", int'(sample_norm), exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sample", int'(sample_norm), 0);
    nrst = 1;
    run(765, 3, 255, 0);
    run(100, 3, 33, 0);
    run(1530, 12, 127, 0);
    run(500, 0, 0, 2);
    run(3060, 2, 255, 0);
    run(200, 1, 200, 0);
    run(4095, 15, 255, 0);
    run(1000, 13, 76, 0);
    run(40, 4, 10, 5);
    @(negedge clk);
    mix_sum = 12'd900; num_signals = 4'd7; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    nrst = 0;
    @(negedge clk);
    nrst = 1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample", int'(sample_norm), 0);
    repeat (20) @(negedge clk);
    chk("abort_no_result", int'(out_valid), 0);
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      mix_sum = 12'($urandom);
      num_signals = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      nrst = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    nrst = 1; in_valid = 0; out_ready = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
